decode_operand: RTL
===================

# decode_operand

Decode/operand-fetch stage placed directly upstream of the execute stage. Splits the fetched instruction word into execute-stage fields, holds the 32-entry general register file, and accepts the execute stage's writeback (result, target, enable) back into it. It registers one decoded instruction per cycle, interlocks on read-after-write hazards, and squashes on a taken branch.

## Interface
- ADDR, 16, PC width
- W_OPR, 32, operand/register width
- W_OPC, 7, opcode width
- W_RD, 5, register index width (32 registers)
- W_IMM, 16, immediate width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- v_i  in  1  instruction valid from fetch
- pc_i  in  ADDR  PC of instruction
- instr_i  in  32  instruction word
- stall_i  in  1  downstream stall, execute's stall_o
- stall_o  out  1  hold request to fetch
- branch_i  in  1  taken branch from execute
- wb_i  in  1  writeback enable, execute's wb_o
- wb_r_i  in  W_RD  writeback register, execute's wb_r_o
- wb_data_i  in  W_OPR  writeback data, execute's result_o
- v_o, pc_o, immf_o, immsign_o, imm_o (W_IMM), stf_o, opecode_o (W_OPC), opr0_o (W_OPR), opr1_o (W_OPR), wb_o, wb_r_o (W_RD)  out  registered decoded fields to execute

## Operation
- Fields: opcode = instr[31:25], rd = instr[24:20], immf = instr[19], immsign = instr[18], rs = instr[4:0], imm = instr[15:0]; instr[17:16] ignored.
- opr0 = R[rd]; opr1 = R[rs] when immf=0, else 0. imm_o always carries instr[15:0].
- stf = (opcode == 7'b001_1001). wb = 1 when opcode[4:0] ∈ {0,1,2,3,5,6,7,8,9,10,12,13,16,17,18,19,22,23,24}; otherwise 0 (CMP, ST, J, JA, NOP, HLT, unused). wb_r_o = rd.
- Register file: 32 × W_OPR. Written at the clock edge when wb_i=1, R[wb_r_i] ← wb_data_i. No hardwired zero register.
- Sources: rd always. rs only when immf=0 and the opcode is not in {J, JA, NOP, HLT, SETL, SETH}.
- Hazard: v_i=1, v_o=1, wb_o=1, and wb_r_o equals a source register, meaning the producer is in execute with its result not yet visible.
- Update rules, in priority order:
  - stall_i=1: all output registers hold.
  - branch_i=1: v_o←0; current input is dropped. Fetch redirects.
  - hazard: v_o←0 (bubble); other outputs don't-care; stall_o=1.
  - otherwise: load decoded fields; v_o←v_i.
- stall_o = stall_i | (hazard & ~branch_i).

## Timing
- Reset: v_o, wb_o, stf_o, immf_o, immsign_o = 0; pc_o, imm_o, opecode_o, opr0_o, opr1_o, wb_r_o = 0; all 32 registers = 0. Reset mid-stream discards the in-flight instruction.
- Latency: 1 cycle from accepted instruction to outputs.
- Dependent back-to-back instruction: exactly one bubble. On the following cycle the producer's result is on wb_data_i and is bypassed.
- Reads while stall_i=1 are re-evaluated each cycle; the held output is not refreshed.
- Simultaneous branch_i and hazard: flush wins and stall_o falls to stall_i.

## Configuration
- DECODE_BYPASS_EN defined: same-cycle write-through. A read of R[wb_r_i] while wb_i=1 returns wb_data_i. Dependence costs one bubble.
- DECODE_BYPASS_EN undefined: no write-through. The hazard also covers wb_i=1 with wb_r_i equal to a source register. Dependence costs two bubbles.

## Test plan
- Reset, then ADD r1,r2 (r2 preloaded to 5, r1 to 3) with no stall: v_o=1 one cycle later; opr0_o=3, opr1_o=5, wb_o=1, wb_r_o=1.
- Immediate form (immf=1, immsign=1, imm=0xFFFE): opr1_o=0; imm_o=0xFFFE; immsign_o=1; no rs hazard even if instr[4:0] matches v_o's wb_r_o.
- ADD r1←… followed by SUB r4,r1: one bubble (v_o=0, stall_o=1 for one cycle). With bypass, SUB's opr1_o equals the result driven on wb_data_i; without bypass, there are two bubbles.
- stall_i held 3 cycles with a valid instruction at the outputs: all outputs are unchanged and stall_o=1 throughout; advance happens on release.
- branch_i=1 with v_i=1 and a concurrent hazard: next v_o=0, stall_o=stall_i, and the input instruction never appears.
- wb_i=1 to r7=0x12345678 while stall_i=1, then a later read of r7: opr0_o=0x12345678. Asserting reset mid-run clears v_o and r7 to 0.

Source files
------------

// File: rtl/decode_operand.sv
// rtl/decode_operand.sv - decode/operand-fetch stage with register file and RAW interlock
//
// Splits the instruction word into execute-stage fields, reads operands from the
// 32-entry register file, accepts execute's writeback, and registers one decoded
// instruction per cycle. Interlocks on read-after-write hazards, squashes on branch.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   v_i, pc_i, instr_i    instruction from fetch
//   stall_i               execute-stage stall; stall_o requests fetch to hold
//   branch_i              taken branch from execute (flush)
//   wb_i, wb_r_i, wb_data_i  writeback from execute into the register file
//   v_o .. wb_r_o         registered decoded fields to execute
//
// Build option DECODE_BYPASS_EN: when defined, a read of the register being
// written this cycle returns wb_data_i (one-bubble dependence); when undefined
// the writeback itself is treated as a hazard (two-bubble dependence).

module decode_operand #(
   parameter int ADDR  = 16,
   parameter int W_OPR = 32,
   parameter int W_OPC = 7,
   parameter int W_RD  = 5,
   parameter int W_IMM = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              v_i,
   input  logic [ADDR-1:0]   pc_i,
   input  logic [31:0]       instr_i,
   input  logic              stall_i,
   output logic              stall_o,
   input  logic              branch_i,
   input  logic              wb_i,
   input  logic [W_RD-1:0]   wb_r_i,
   input  logic [W_OPR-1:0]  wb_data_i,
   output logic              v_o,
   output logic [ADDR-1:0]   pc_o,
   output logic              immf_o,
   output logic              immsign_o,
   output logic [W_IMM-1:0]  imm_o,
   output logic              stf_o,
   output logic [W_OPC-1:0]  opecode_o,
   output logic [W_OPR-1:0]  opr0_o,
   output logic [W_OPR-1:0]  opr1_o,
   output logic              wb_o,
   output logic [W_RD-1:0]   wb_r_o
);

   // Low five opcode bits of the ops that never read rs.
   localparam logic [4:0] OP_SETL = 5'd22;
   localparam logic [4:0] OP_SETH = 5'd23;
   localparam logic [4:0] OP_J    = 5'd26;
   localparam logic [4:0] OP_JA   = 5'd27;
   localparam logic [4:0] OP_NOP  = 5'd30;
   localparam logic [4:0] OP_HLT  = 5'd31;
   localparam logic [6:0] OP_ST   = 7'b001_1001;

   // Instruction fields
   logic [W_OPC-1:0] opc;
   logic [W_RD-1:0]  rd;
   logic [W_RD-1:0]  rs;
   logic             immf;
   logic             immsign;
   logic [W_IMM-1:0] imm;
   logic             unused_bits;

   assign opc         = instr_i[31:25];
   assign rd          = instr_i[24:20];
   assign immf        = instr_i[19];
   assign immsign     = instr_i[18];
   assign rs          = instr_i[4:0];
   assign imm         = instr_i[15:0];
   assign unused_bits = ^instr_i[17:16];

   // Decode
   logic dec_wb;
   logic dec_stf;
   logic use_rs;

   always_comb begin
      dec_wb = 1'b0;
      case (opc[4:0])
         5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
         5'd12, 5'd13, 5'd16, 5'd17, 5'd18, 5'd19, 5'd22, 5'd23, 5'd24:
            dec_wb = 1'b1;
         default:
            dec_wb = 1'b0;
      endcase
   end

   assign dec_stf = (opc == OP_ST);
   assign use_rs  = !immf &&
                    !(opc[4:0] inside {OP_J, OP_JA, OP_NOP, OP_HLT, OP_SETL, OP_SETH});

   // Register file
   logic [W_OPR-1:0] rf_q [32];
   logic [W_OPR-1:0] rf_d [32];

   always_comb begin
      rf_d = rf_q;
      if (wb_i) begin
         rf_d[wb_r_i] = wb_data_i;
      end
   end

   // Operand read, optionally forwarding the writeback of this same cycle
   logic [W_OPR-1:0] rd_val;
   logic [W_OPR-1:0] rs_val;

   always_comb begin
      rd_val = rf_q[rd];
      rs_val = rf_q[rs];
`ifdef DECODE_BYPASS_EN
      if (wb_i && (wb_r_i == rd)) rd_val = wb_data_i;
      if (wb_i && (wb_r_i == rs)) rs_val = wb_data_i;
`endif
   end

   // Output registers
   logic             v_q,       v_d;
   logic [ADDR-1:0]  pc_q,      pc_d;
   logic             immf_q,    immf_d;
   logic             immsign_q, immsign_d;
   logic [W_IMM-1:0] imm_q,     imm_d;
   logic             stf_q,     stf_d;
   logic [W_OPC-1:0] opc_q,     opc_d;
   logic [W_OPR-1:0] opr0_q,    opr0_d;
   logic [W_OPR-1:0] opr1_q,    opr1_d;
   logic             wb_q,      wb_d;
   logic [W_RD-1:0]  wb_r_q,    wb_r_d;

   // Hazard: producer sits in execute (our output register) and its result is
   // not yet in the register file.
   logic hazard_ex;
   logic hazard;

   assign hazard_ex = v_i && v_q && wb_q &&
                      ((wb_r_q == rd) || (use_rs && (wb_r_q == rs)));

`ifdef DECODE_BYPASS_EN
   assign hazard = hazard_ex;
`else
   // Without write-through the value being written this cycle is not readable yet.
   assign hazard = hazard_ex ||
                   (v_i && wb_i && ((wb_r_i == rd) || (use_rs && (wb_r_i == rs))));
`endif

   assign stall_o = stall_i | (hazard & ~branch_i);

   always_comb begin
      v_d       = v_q;
      pc_d      = pc_q;
      immf_d    = immf_q;
      immsign_d = immsign_q;
      imm_d     = imm_q;
      stf_d     = stf_q;
      opc_d     = opc_q;
      opr0_d    = opr0_q;
      opr1_d    = opr1_q;
      wb_d      = wb_q;
      wb_r_d    = wb_r_q;
      if (stall_i) begin
         // hold everything
      end else if (branch_i) begin
         v_d = 1'b0;
      end else if (hazard) begin
         v_d = 1'b0;
      end else begin
         v_d       = v_i;
         pc_d      = pc_i;
         immf_d    = immf;
         immsign_d = immsign;
         imm_d     = imm;
         stf_d     = dec_stf;
         opc_d     = opc;
         opr0_d    = rd_val;
         opr1_d    = immf ? '0 : rs_val;
         wb_d      = dec_wb;
         wb_r_d    = rd;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_q       <= 1'b0;
         pc_q      <= '0;
         immf_q    <= 1'b0;
         immsign_q <= 1'b0;
         imm_q     <= '0;
         stf_q     <= 1'b0;
         opc_q     <= '0;
         opr0_q    <= '0;
         opr1_q    <= '0;
         wb_q      <= 1'b0;
         wb_r_q    <= '0;
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         v_q       <= v_d;
         pc_q      <= pc_d;
         immf_q    <= immf_d;
         immsign_q <= immsign_d;
         imm_q     <= imm_d;
         stf_q     <= stf_d;
         opc_q     <= opc_d;
         opr0_q    <= opr0_d;
         opr1_q    <= opr1_d;
         wb_q      <= wb_d;
         wb_r_q    <= wb_r_d;
         rf_q      <= rf_d;
      end
   end

   assign v_o       = v_q;
   assign pc_o      = pc_q;
   assign immf_o    = immf_q;
   assign immsign_o = immsign_q;
   assign imm_o     = imm_q;
   assign stf_o     = stf_q;
   assign opecode_o = opc_q;
   assign opr0_o    = opr0_q;
   assign opr1_o    = opr1_q;
   assign wb_o      = wb_q;
   assign wb_r_o    = wb_r_q;

endmodule
